fp_result_packer: RTL and testbench

FP_RESULT_PACKER -- requirements
Module: fp_result_packer

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_result_packer_if.sv | 26 ++
 rtl/shiftReg25.sv | 22 ++
 rtl/fp_result_packer.sv | 144 ++++++++++++++
 tb/tb_fp_result_packer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the single-precision result packer
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_SAT = 8'd254;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHR,
    SHL,
    HOLD
  } state_t;

  // Assemble an IEEE single-precision word from its fields
  function automatic logic [31:0] pack_word(logic sign, logic [EXP_W-1:0] exp,
                                            logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_result_packer_if.sv
// rtl/fp_result_packer_if.sv - input/output handshake bundle of the result packer
interface fp_result_packer_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic              out_ovf;
  logic              out_unf;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_word, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_word, out_ovf, out_unf
  );

endinterface

// File: rtl/shiftReg25.sv
// rtl/shiftReg25.sv - 25-bit mantissa register with load and one-bit left/right shift
module shiftReg25
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shr,
  input  logic              shl,
  input  logic [MANT_W-1:0] din,
  output logic [MANT_W-1:0] q
);

  // Load wins over shifting; right shift truncates the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= din;
    else if (shr)  q <= {1'b0, q[MANT_W-1:1]};
    else if (shl)  q <= {q[MANT_W-2:0], 1'b0};
  end

endmodule

// File: rtl/fp_result_packer.sv
// rtl/fp_result_packer.sv - normalizes a raw adder result and packs it into an IEEE word
module fp_result_packer
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fp_result_packer_if.slave bus
);

  state_t             state, state_nxt;
  logic               sign_q;
  logic [EXP_W-1:0]   exp_q;
  logic [MANT_W-1:0]  mant_q;
  logic               ovf_q, unf_q;

  logic               mant_load, mant_shr, mant_shl;
  logic [MANT_W-1:0]  mant_din;
  logic               exp_load, exp_inc, exp_dec;
  logic [EXP_W-1:0]   exp_din;
  logic               accept, set_ovf, set_unf;

  assign accept = (state == IDLE) && bus.in_valid;

  shiftReg25 u_mant (
    .clk   (clk),
    .rst_n (rst),
    .load  (mant_load),
    .shr   (mant_shr),
    .shl   (mant_shl),
    .din   (mant_din),
    .q     (mant_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state plus mantissa/exponent/flag controls
  always_comb begin
    state_nxt = state;
    mant_load = 1'b0;
    mant_shr  = 1'b0;
    mant_shl  = 1'b0;
    mant_din  = bus.in_mant;
    exp_load  = 1'b0;
    exp_inc   = 1'b0;
    exp_dec   = 1'b0;
    exp_din   = bus.in_exp;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = CHECK;
          mant_load = 1'b1;
          exp_load  = 1'b1;
        end
      end
      CHECK: begin
        if (mant_q == '0) begin
          state_nxt = HOLD;
          exp_load  = 1'b1;
          exp_din   = '0;
        end else if (exp_q == EXP_MAX || (mant_q[MANT_W-1] && exp_q == EXP_SAT)) begin
          state_nxt = HOLD;
          set_ovf   = 1'b1;
        end else if (exp_q == '0) begin
          state_nxt = HOLD;
          set_unf   = 1'b1;
          mant_load = 1'b1;
          mant_din  = '0;
        end else if (mant_q[MANT_W-1]) begin
          state_nxt = SHR;
        end else if (mant_q[FRAC_W]) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = SHL;
        end
      end
      SHR: begin
        mant_shr  = 1'b1;
        exp_inc   = 1'b1;
        state_nxt = HOLD;
      end
      SHL: begin
        // Entered only with the hidden bit clear; leave on the shift that sets it
        if (exp_q == 8'd1) begin
          state_nxt = HOLD;
          set_unf   = 1'b1;
          mant_load = 1'b1;
          mant_din  = '0;
          exp_load  = 1'b1;
          exp_din   = '0;
        end else begin
          mant_shl = 1'b1;
          exp_dec  = 1'b1;
          if (mant_q[FRAC_W-1]) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Exponent up/down counter and captured sign
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      if (accept) sign_q <= bus.in_sign;
      if (exp_load)     exp_q <= exp_din;
      else if (exp_inc) exp_q <= exp_q + 8'd1;
      else if (exp_dec) exp_q <= exp_q - 8'd1;
    end
  end

  // Saturation/flush flags, cleared on every new accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_ovf   = bus.out_valid & ovf_q;
  assign bus.out_unf   = bus.out_valid & unf_q;
  assign bus.out_word  = !bus.out_valid ? 32'h0 :
                         ovf_q ? (sign_q ? NEG_INF : POS_INF) :
                         pack_word(sign_q, exp_q, mant_q[FRAC_W-1:0]);

endmodule

// File: tb/tb_fp_result_packer.sv
// tb/tb_fp_result_packer.sv - self-checking bench for fp_result_packer
module tb_fp_result_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_result_packer_if bus();

  fp_result_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [31:0] word;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(logic s, logic [7:0] e, logic [24:0] m, logic [31:0] w,
                              logic o, logic u, int l);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.word = w; v.ovf = o; v.unf = u; v.lat = l;
    return v;
  endfunction

  // Reference: normalize with plain arithmetic on the numeric value
  function automatic vec_t model(logic s, logic [7:0] e, logic [24:0] m);
    int msb, k;
    int ei;
    logic [24:0] sh;
    ei = int'(e);
    if (m == 0) return mk(s, e, m, {s, 31'h0}, 1'b0, 1'b0, 2);
    if (ei == 255 || (m[24] && ei == 254)) return mk(s, e, m, {s, 8'hFF, 23'h0}, 1'b1, 1'b0, 2);
    if (ei == 0) return mk(s, e, m, {s, 31'h0}, 1'b0, 1'b1, 2);
    if (m[24]) return mk(s, e, m, {s, 8'(ei + 1), m[23:1]}, 1'b0, 1'b0, 3);
    msb = 0;
    for (int i = 0; i < 25; i++) if (m[i]) msb = i;
    k = 23 - msb;
    if (ei - k >= 1) begin
      sh = m << k;
      return mk(s, e, m, {s, 8'(ei - k), sh[22:0]}, 1'b0, 1'b0, 2 + k);
    end
    return mk(s, e, m, {s, 31'h0}, 1'b0, 1'b1, ei + 2);
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    check({tag, " in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = v.sign;
    bus.in_exp   = v.exp;
    bus.in_mant  = v.mant;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'($urandom);
    bus.in_exp   = 8'($urandom);
    bus.in_mant  = 25'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, 32'(n + 1), 32'(v.lat));
    check({tag, " out_word"}, bus.out_word, v.word);
    check({tag, " out_ovf"}, 32'(bus.out_ovf), 32'(v.ovf));
    check({tag, " out_unf"}, 32'(bus.out_unf), 32'(v.unf));
    check({tag, " flags_exclusive"}, 32'(bus.out_ovf & bus.out_unf), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, " out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0]  re;
    logic [24:0] rm;
    int          n;

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;

    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_word", bus.out_word, 32'h0);
    check("reset flags", {30'h0, bus.out_ovf, bus.out_unf}, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(1'b0, 8'd127, 25'h0800000, 32'h3F80_0000, 1'b0, 1'b0, 2));
    tbl.push_back(mk(1'b0, 8'd127, 25'h1800000, 32'h4040_0000, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b0, 8'd130, 25'h0200000, 32'h4000_0000, 1'b0, 1'b0, 4));
    tbl.push_back(mk(1'b1, 8'd254, 25'h1000000, 32'hFF80_0000, 1'b1, 1'b0, 2));
    tbl.push_back(mk(1'b0, 8'd2,   25'h0000001, 32'h0000_0000, 1'b0, 1'b1, 4));
    tbl.push_back(mk(1'b0, 8'd255, 25'h0800000, 32'h7F80_0000, 1'b1, 1'b0, 2));
    tbl.push_back(mk(1'b1, 8'd50,  25'h0000000, 32'h8000_0000, 1'b0, 1'b0, 2));
    tbl.push_back(mk(1'b0, 8'd0,   25'h0800000, 32'h0000_0000, 1'b0, 1'b1, 2));
    tbl.push_back(mk(1'b0, 8'd1,   25'h0400000, 32'h0000_0000, 1'b0, 1'b1, 3));
    tbl.push_back(mk(1'b0, 8'd100, 25'h0000001, 32'h2680_0000, 1'b0, 1'b0, 25));
    tbl.push_back(mk(1'b0, 8'd254, 25'h0800000, 32'h7F00_0000, 1'b0, 1'b0, 2));
    tbl.push_back(mk(1'b0, 8'd253, 25'h1000001, 32'h7F00_0000, 1'b0, 1'b0, 3));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Output held back for 10 cycles
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = 8'd127; bus.in_mant = 25'h0800000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("hold reached", 32'(bus.out_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold word c%0d", c), bus.out_word, 32'h3F80_0000);
      check($sformatf("hold in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("hold out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold release in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a 20-shift normalization
    bus.in_valid = 1'b1; bus.in_sign = 1'b1; bus.in_exp = 8'd100; bus.in_mant = 25'h0000008;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset out_word", bus.out_word, 32'h0);
    check("midreset flags", {30'h0, bus.out_ovf, bus.out_unf}, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(1'b0, 8'd100, 25'h0000008, 32'h2800_0000, 1'b0, 1'b0, 22), "after_reset");

    // Randomized vectors against the reference
    for (int r = 0; r < 150; r++) begin
      re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      rm = 25'($urandom) >> $urandom_range(0, 25);
      run_vec(model(1'($urandom), re, rm), $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
